// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Hazard and stall control for a five-stage pipeline. It handles load-use
//   and branch-compare data hazards. It holds EX while a multi-cycle MUL runs,
//   and it squashes the wrong-path fetch on a taken redirect in ID.
//   Optional feature macro: HAZARD_FORWARDING_EN. When it is defined, EX/MEM
//   forwarding resolves ordinary RAW hazards. When it is undefined, any
//   producer still in EX or MEM stalls a consumer in ID.
module pipeline_stall_controller #(
    parameter int unsigned MUL_CYCLES = 3   // EX cycles per MUL, 1..15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       ID_CompareUse,
    input  logic       ID_Taken,
    input  logic       ID_Mul,
    input  logic [4:0] EX_Rd,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic [4:0] MEM_Rd,
    input  logic       MEM_RegWrite,
    input  logic       MEM_MemRead,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IDEX_Write,
    output logic       IDEX_Bubble,
    output logic       EXMEM_Bubble,
    output logic       IFID_Flush,
    output logic       MulBusy
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // Cycles still spent in MUL_WAIT after the MUL is accepted from ID.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       match_ex, match_mem;
    logic       data_stall;

    // RAW detection against the EX and MEM destinations; $0 is never a producer.
    always_comb begin
        match_ex  = EX_RegWrite && (EX_Rd != 5'd0) &&
                    ((ID_UsesRs && (EX_Rd == ID_rs)) || (ID_UsesRt && (EX_Rd == ID_rt)));
        match_mem = MEM_RegWrite && (MEM_Rd != 5'd0) &&
                    ((ID_UsesRs && (MEM_Rd == ID_rs)) || (ID_UsesRt && (MEM_Rd == ID_rt)));
    end

    // Stall decision: load-use, and branch compare operands that are not ready yet.
    always_comb begin
        data_stall = (EX_MemRead && match_ex) ||
                     (ID_CompareUse && match_ex) ||
                     (ID_CompareUse && MEM_MemRead && match_mem);
`ifndef HAZARD_FORWARDING_EN
        // No forwarding paths exist, so every in-flight producer must retire first.
        data_stall = data_stall || match_ex || match_mem;
`endif
    end

    // Output decode. Priority is reset, then MUL hold, then data stall, then redirect.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path can infer a latch.
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        IFID_Flush   = 1'b0;
        MulBusy      = 1'b0;
        if (Rst) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            IDEX_Bubble  = 1'b1;
            EXMEM_Bubble = 1'b1;
        end else if (state_q == MUL_WAIT) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            MulBusy      = 1'b1;
        end else if (data_stall) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Bubble  = 1'b1;
        end else begin
            IFID_Flush   = ID_Taken;
        end
    end

    // Next-state logic: accept a multi-cycle MUL, then count down its hold cycles.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            RUN: begin
                if (ID_Mul && !data_stall && (MUL_CYCLES > 1)) begin
                    state_d   = MUL_WAIT;
                    mul_cnt_d = MUL_CNT_INIT;
                end
            end
            MUL_WAIT: begin
                mul_cnt_d = mul_cnt_q - 4'd1;
                if (mul_cnt_q <= 4'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d   = RUN;
                mul_cnt_d = 4'd0;
            end
        endcase
    end

    // State register with asynchronous reset. Reset abandons any MUL in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller
//   Directed bench for pipeline_stall_controller. A spec-level model predicts
//   every output on each falling clock edge. Hand-computed literals at the key
//   points of each scenario pin the model itself. A second instance built with
//   MUL_CYCLES=1 confirms that a single-cycle MUL never holds EX.
module tb_pipeline_stall_controller;

    localparam int MUL_CYCLES = 3;

    // Output vector order: {PC, IFID_W, IDEX_W, IDEX_B, EXMEM_B, FLUSH, BUSY}
    localparam logic [6:0] V_RESET = 7'b0001100;
    localparam logic [6:0] V_RUN   = 7'b1110000;
    localparam logic [6:0] V_STALL = 7'b0011000;
    localparam logic [6:0] V_FLUSH = 7'b1110010;
    localparam logic [6:0] V_MUL   = 7'b0000101;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] ID_rs, ID_rt, EX_Rd, MEM_Rd;
    logic       ID_UsesRs, ID_UsesRt, ID_CompareUse, ID_Taken, ID_Mul;
    logic       EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;

    logic PC_Write, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, IFID_Flush, MulBusy;
    logic PC_Write1, IFID_Write1, IDEX_Write1, IDEX_Bubble1, EXMEM_Bubble1, IFID_Flush1, MulBusy1;

    int tests  = 0;
    int errors = 0;

    pipeline_stall_controller #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .Clk(Clk), .Rst(Rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_CompareUse(ID_CompareUse), .ID_Taken(ID_Taken), .ID_Mul(ID_Mul),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
        .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
        .IFID_Flush(IFID_Flush), .MulBusy(MulBusy)
    );

    pipeline_stall_controller #(.MUL_CYCLES(1)) dut1 (
        .Clk(Clk), .Rst(Rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_CompareUse(ID_CompareUse), .ID_Taken(ID_Taken), .ID_Mul(ID_Mul),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .PC_Write(PC_Write1), .IFID_Write(IFID_Write1), .IDEX_Write(IDEX_Write1),
        .IDEX_Bubble(IDEX_Bubble1), .EXMEM_Bubble(EXMEM_Bubble1),
        .IFID_Flush(IFID_Flush1), .MulBusy(MulBusy1)
    );

    always #5 Clk = ~Clk;

    wire [6:0] out_vec  = {PC_Write, IFID_Write, IDEX_Write, IDEX_Bubble,
                           EXMEM_Bubble, IFID_Flush, MulBusy};
    wire [6:0] out_vec1 = {PC_Write1, IFID_Write1, IDEX_Write1, IDEX_Bubble1,
                           EXMEM_Bubble1, IFID_Flush1, MulBusy1};

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model counts the cycles that remain in which the MUL still owns EX.
    int busy_left = 0;

    function automatic logic reads(input logic [4:0] rd);
        return (rd != 5'd0) && ((ID_UsesRs && rd == ID_rs) || (ID_UsesRt && rd == ID_rt));
    endfunction

    function automatic logic hazard();
        logic ex_hit, mem_hit, s;
        ex_hit  = EX_RegWrite  && reads(EX_Rd);
        mem_hit = MEM_RegWrite && reads(MEM_Rd);
        s = (ex_hit && (EX_MemRead || ID_CompareUse)) ||
            (ID_CompareUse && MEM_MemRead && mem_hit);
`ifndef HAZARD_FORWARDING_EN
        s = s || ex_hit || mem_hit;
`endif
        return s;
    endfunction

    function automatic logic [6:0] expect_vec(input logic busy);
        if (Rst)      return V_RESET;
        if (busy)     return V_MUL;
        if (hazard()) return V_STALL;
        return {6'b111000, 1'b0} | {5'b0, ID_Taken, 1'b0};
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst)
            busy_left = 0;
        else if (busy_left > 0)
            busy_left = busy_left - 1;
        else if (ID_Mul && !hazard() && MUL_CYCLES > 1)
            busy_left = MUL_CYCLES - 1;
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge Clk) begin
        check("model", out_vec, expect_vec(busy_left > 0));
        check("model_mul1", out_vec1, expect_vec(1'b0));
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        ID_CompareUse = 1'b0; ID_Taken = 1'b0; ID_Mul = 1'b0;
        EX_Rd = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
        MEM_Rd = 5'd0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        Rst = 1'b1;
        clear_inputs();
        #2 check("reset_outputs", out_vec, V_RESET);
        @(posedge Clk); #1 Rst = 1'b0;
        #1 check("post_reset_run", out_vec, V_RUN);

        // Load-use on rs: one bubble, then released once the load leaves EX.
        next_cycle();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd8; ID_rs = 5'd8; ID_UsesRs = 1'b1;
        #1 check("load_use_stall", out_vec, V_STALL);
        next_cycle();
        ID_rs = 5'd8; ID_UsesRs = 1'b1;
        #1 check("load_use_release", out_vec, V_RUN);

        // Branch after ALU op: stall (Taken ignored), then flush for one cycle.
        next_cycle();
        ID_CompareUse = 1'b1; ID_UsesRt = 1'b1; ID_rt = 5'd9; ID_Taken = 1'b1;
        EX_Rd = 5'd9; EX_RegWrite = 1'b1;
        #1 check("branch_stall_no_flush", out_vec, V_STALL);
        next_cycle();
        ID_CompareUse = 1'b1; ID_UsesRt = 1'b1; ID_rt = 5'd9; ID_Taken = 1'b1;
        #1 check("branch_flush", out_vec, V_FLUSH);
        next_cycle();
        #1 check("flush_one_cycle", out_vec, V_RUN);

        // Branch depending on a load sitting in MEM.
        next_cycle();
        ID_CompareUse = 1'b1; ID_UsesRs = 1'b1; ID_rs = 5'd12;
        MEM_Rd = 5'd12; MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1;
        #1 check("branch_mem_load_stall", out_vec, V_STALL);

        // MUL: accept cycle runs normally, then two held cycles, then RUN.
        next_cycle();
        ID_Mul = 1'b1;
        #1 check("mul_accept", out_vec, V_RUN);
        next_cycle();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd3; ID_rs = 5'd3;
        ID_UsesRs = 1'b1; ID_Taken = 1'b1;
        #1 check("mul_wait_1_priority", out_vec, V_MUL);
        next_cycle();
        #1 check("mul_wait_2", out_vec, V_MUL);
        next_cycle();
        #1 check("mul_done", out_vec, V_RUN);

        // Register $0 never stalls; a plain ALU producer stalls only without forwarding.
        next_cycle();
        EX_Rd = 5'd0; EX_RegWrite = 1'b1; EX_MemRead = 1'b1; ID_rs = 5'd0; ID_UsesRs = 1'b1;
        ID_CompareUse = 1'b1;
        #1 check("reg0_no_stall", out_vec, V_RUN);
        next_cycle();
        EX_Rd = 5'd5; EX_RegWrite = 1'b1; ID_rs = 5'd5; ID_UsesRs = 1'b1;
`ifdef HAZARD_FORWARDING_EN
        #1 check("alu_ex_dep", out_vec, V_RUN);
`else
        #1 check("alu_ex_dep", out_vec, V_STALL);
`endif
        next_cycle();
        MEM_Rd = 5'd6; MEM_RegWrite = 1'b1; ID_rt = 5'd6; ID_UsesRt = 1'b1;
`ifdef HAZARD_FORWARDING_EN
        #1 check("alu_mem_dep", out_vec, V_RUN);
`else
        #1 check("alu_mem_dep", out_vec, V_STALL);
`endif
        next_cycle();
        EX_Rd = 5'd7; EX_RegWrite = 1'b1; EX_MemRead = 1'b1; ID_rs = 5'd7; ID_UsesRs = 1'b0;
        #1 check("unused_operand_no_stall", out_vec, V_RUN);

        // Asynchronous reset in the last MUL_WAIT cycle (count 1).
        next_cycle();
        ID_Mul = 1'b1;
        next_cycle();
        next_cycle();
        #1 check("mul_wait_cnt1", out_vec, V_MUL);
        #2 Rst = 1'b1;
        #1 check("async_reset_mid_mul", out_vec, V_RESET);
        #1 Rst = 1'b0;
        #1 check("after_reset_run", out_vec, V_RUN);
        next_cycle();
        #1 check("mul_abandoned", out_vec, V_RUN);

        next_cycle();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
